// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment capture block:
//   - segment bit order within a 7-bit pattern (bit0 = a ... bit6 = g)
//   - the sixteen hex-digit segment codes (active-low, written g..a)
//   - the all-off blank code
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Position of each segment line within the 7-bit pattern.
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  localparam int unsigned SEG_W = 7;

  // Active-low: a 0 bit means the segment is lit.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_CODE_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_CODE_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_CODE_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_CODE_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_CODE_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_CODE_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_CODE_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_CODE_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_CODE_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_CODE_F = 7'b0001110;

  // Indexed by nibble value: SEG_CODES[n] is the pattern that displays n.
  localparam logic [15:0][SEG_W-1:0] SEG_CODES = {
    SEG_CODE_F, SEG_CODE_E, SEG_CODE_D, SEG_CODE_C,
    SEG_CODE_B, SEG_CODE_A, SEG_CODE_9, SEG_CODE_8,
    SEG_CODE_7, SEG_CODE_6, SEG_CODE_5, SEG_CODE_4,
    SEG_CODE_3, SEG_CODE_2, SEG_CODE_1, SEG_CODE_0
  };

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational segment-pattern decoder.
//   i_seg    : 7-bit active-low segment pattern (bit0 = a ... bit6 = g)
//   o_nibble : hex value displayed by i_seg (0 when not a legal code)
//   o_hit    : i_seg is one of the sixteen hex-digit codes
//   o_blank  : i_seg is the all-off pattern
// -----------------------------------------------------------------------------
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] i_seg,
  output logic [3:0]       o_nibble,
  output logic             o_hit,
  output logic             o_blank
);

  always_comb begin
    o_nibble = '0;
    o_hit    = 1'b0;
    for (int unsigned k = 0; k < 16; k++) begin
      if (i_seg == SEG_CODES[k]) begin
        o_hit    = 1'b1;
        o_nibble = 4'(k);
      end
    end
    o_blank = (i_seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_capture.sv
// -----------------------------------------------------------------------------
// seg7_capture
// Captures the digits shown on a multiplexed seven-segment display by sniffing
// its segment and digit-select lines. Both buses are synchronized, and a digit
// is committed once {dig_sel, seg_in} has been stable for STABLE_CYCLES
// consecutive samples.
//   clk         : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   seg_in      : segment lines, active-low, bit0 = a ... bit6 = g (async)
//   dig_sel     : digit enables, active-high, expected one-hot (async)
//   err_clr     : synchronous pulse clearing seg_err / sel_err
//   digits      : captured nibble per digit, digit i at [4i+3:4i]
//   digit_valid : bit i set when digits[i] holds a legally decoded value
//   update      : one-cycle pulse on every digit commit
//   upd_idx     : index of the digit committed with update
//   seg_err     : sticky, an illegal segment pattern was committed
//   sel_err     : sticky, a stable multi-hot dig_sel was seen
// -----------------------------------------------------------------------------
module seg7_capture
  import seg7_pkg::*;
#(
  parameter  int unsigned STABLE_CYCLES = 4,
  parameter  int unsigned NDIG          = 4,
  localparam int unsigned IDXW          = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SEG_W-1:0]    seg_in,
  input  logic [NDIG-1:0]     dig_sel,
  input  logic                err_clr,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_valid,
  output logic                update,
  output logic [IDXW-1:0]     upd_idx,
  output logic                seg_err,
  output logic                sel_err
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  // Synchronizers and the previous-cycle copy used for the stability compare.
  logic [SEG_W-1:0]  r_seg_s1, r_seg_s2, r_seg_prev;
  logic [NDIG-1:0]   r_sel_s1, r_sel_s2, r_sel_prev;

  logic [7:0]        r_cnt;
  logic              r_done;

  logic [4*NDIG-1:0] r_digits;
  logic [NDIG-1:0]   r_valid;
  logic              r_update;
  logic [IDXW-1:0]   r_upd_idx;
  logic              r_seg_err;
  logic              r_sel_err;

  logic              w_same;
  logic [7:0]        w_cnt_next;
  logic              w_fire;
  logic              w_onehot;
  logic              w_multi;
  logic [IDXW-1:0]   w_idx;
  logic [3:0]        w_nibble;
  logic              w_hit;
  logic              w_blank;
  logic              w_seg_set;
  logic              w_sel_set;

  seg7_decode u_decode (
    .i_seg    (r_seg_s2),
    .o_nibble (w_nibble),
    .o_hit    (w_hit),
    .o_blank  (w_blank)
  );

  assign w_same = ({r_sel_s2, r_seg_s2} == {r_sel_prev, r_seg_prev});

  // Saturating run-length counter; a change starts a new run at 1.
  always_comb begin
    w_cnt_next = 8'd1;
    if (w_same) begin
      w_cnt_next = (r_cnt < STABLE_MAX) ? r_cnt + 8'd1 : r_cnt;
    end
  end

  // r_done blocks further commits until the run is broken, so a run that
  // sits at saturation commits exactly once.
  assign w_fire   = w_same && (w_cnt_next == STABLE_MAX) && !r_done;

  assign w_onehot = $onehot(r_sel_s2);
  assign w_multi  = ($countones(r_sel_s2) > 1);

  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_sel_s2[i]) begin
        w_idx = IDXW'(i);
      end
    end
  end

  assign w_seg_set = w_fire && w_onehot && !w_hit && !w_blank;
  assign w_sel_set = w_fire && w_multi;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1   <= SEG_BLANK;
      r_seg_s2   <= SEG_BLANK;
      r_seg_prev <= SEG_BLANK;
      r_sel_s1   <= '0;
      r_sel_s2   <= '0;
      r_sel_prev <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_digits   <= '0;
      r_valid    <= '0;
      r_update   <= 1'b0;
      r_upd_idx  <= '0;
      r_seg_err  <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_seg_s1   <= seg_in;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_sel_s1   <= dig_sel;
      r_sel_s2   <= r_sel_s1;
      r_sel_prev <= r_sel_s2;

      r_cnt      <= w_cnt_next;
      r_done     <= w_same && (r_done || w_fire);

      r_update   <= w_fire && w_onehot;
      if (w_fire && w_onehot) begin
        r_upd_idx <= w_idx;
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (r_sel_s2[i]) begin
            r_valid[i] <= w_hit;
            if (w_hit) begin
              r_digits[4*i +: 4] <= w_nibble;
            end
          end
        end
      end

      // A set in the same cycle as err_clr takes priority.
      r_seg_err <= w_seg_set || (r_seg_err && !err_clr);
      r_sel_err <= w_sel_set || (r_sel_err && !err_clr);
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign update      = r_update;
  assign upd_idx     = r_upd_idx;
  assign seg_err     = r_seg_err;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;

  localparam int unsigned SC = 4;
  localparam int unsigned ND = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_sel;
  logic        err_clr;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic [1:0]  upd_idx;
  logic        seg_err;
  logic        sel_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int upd_cnt = 0;
  int upd_q[$];

  // Reference table of legal patterns (g..a), index = displayed value.
  logic [6:0] codes [16];

  always #5 clk = ~clk;

  seg7_capture #(
    .STABLE_CYCLES (SC),
    .NDIG          (ND)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .err_clr     (err_clr),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .upd_idx     (upd_idx),
    .seg_err     (seg_err),
    .sel_err     (sel_err)
  );

  always @(negedge clk) begin
    if (update === 1'b1) begin
      upd_cnt++;
      upd_q.push_back(int'(upd_idx));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Holds pins for d rising edges; call and return at posedge+1 phase.
  task automatic hold(input logic [3:0] s, input logic [6:0] g, input int d);
    dig_sel = s;
    seg_in  = g;
    repeat (d) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; dig_sel = '0; seg_in = 7'h7f; err_clr = 1'b0;
    #1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (digits !== 16'h0) begin n_fail++; $display("FAIL reset_digits: got %h expected 0000", digits); end
    n_cmp++; if (digit_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0000", digit_valid); end
    n_cmp++; if (update !== 1'b0) begin n_fail++; $display("FAIL reset_update: got %b expected 0", update); end
    n_cmp++; if (upd_idx !== 2'd0) begin n_fail++; $display("FAIL reset_upd_idx: got %0d expected 0", upd_idx); end
    n_cmp++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL reset_seg_err: got %b expected 0", seg_err); end
    n_cmp++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err: got %b expected 0", sel_err); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({update, digit_valid} !== 5'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 00000", {update, digit_valid}); end
  endtask

  task automatic test_latency();
    int base;
    base = upd_cnt;
    dig_sel = 4'b0001;
    seg_in  = 7'b0100100;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (update !== (e == SC + 2)) begin n_fail++; $display("FAIL latency_edge%0d: update got %b expected %b", e, update, (e == SC + 2)); end
      if (e == SC + 2) begin
        n_cmp++; if (upd_idx !== 2'd0) begin n_fail++; $display("FAIL latency_idx: got %0d expected 0", upd_idx); end
      end
    end
    n_cmp++; if (upd_cnt - base != 1) begin n_fail++; $display("FAIL latency_pulses: got %0d expected 1", upd_cnt - base); end
    n_cmp++; if (digits[3:0] !== 4'h2) begin n_fail++; $display("FAIL latency_digit0: got %h expected 2", digits[3:0]); end
    n_cmp++; if (digit_valid !== 4'b0001) begin n_fail++; $display("FAIL latency_valid: got %b expected 0001", digit_valid); end
  endtask

  task automatic test_scan();
    int base;
    logic [15:0] shown;
    shown = 16'h1A3F;
    base = upd_cnt;
    upd_q.delete();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        hold(4'b0001 << i, codes[shown[4*i +: 4]], 8);
      end
      n_cmp++; if (upd_cnt - base != 4 * (s + 1)) begin n_fail++; $display("FAIL scan_pulses%0d: got %0d expected %0d", s, upd_cnt - base, 4 * (s + 1)); end
    end
    n_cmp++; if (digits !== 16'h1A3F) begin n_fail++; $display("FAIL scan_digits: got %h expected 1a3f", digits); end
    n_cmp++; if (digit_valid !== 4'b1111) begin n_fail++; $display("FAIL scan_valid: got %b expected 1111", digit_valid); end
    n_cmp++; if (upd_q.size() != 8) begin n_fail++; $display("FAIL scan_idx_count: got %0d expected 8", upd_q.size()); end
    for (int k = 0; k < upd_q.size() && k < 8; k++) begin
      n_cmp++; if (upd_q[k] != k % 4) begin n_fail++; $display("FAIL scan_idx%0d: got %0d expected %0d", k, upd_q[k], k % 4); end
    end
  endtask

  task automatic test_toggle();
    int base;
    base = upd_cnt;
    for (int t = 0; t < 8; t++) begin
      hold(4'b0100, (t % 2 == 1) ? 7'b0000000 : 7'b1000000, SC - 1);
    end
    n_cmp++; if (upd_cnt != base) begin n_fail++; $display("FAIL toggle_pulses: got %0d expected 0", upd_cnt - base); end
    n_cmp++; if (digits !== 16'h1A3F) begin n_fail++; $display("FAIL toggle_digits: got %h expected 1a3f", digits); end
    hold(4'b0100, 7'b0000110, 8);
    n_cmp++; if (upd_cnt - base != 1) begin n_fail++; $display("FAIL toggle_hold_pulses: got %0d expected 1", upd_cnt - base); end
    n_cmp++; if (digits !== 16'h1E3F) begin n_fail++; $display("FAIL toggle_hold_digits: got %h expected 1e3f", digits); end
  endtask

  task automatic test_seg_err();
    int base;
    base = upd_cnt;
    n_cmp++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL segerr_initial: got %b expected 0", seg_err); end
    hold(4'b0010, 7'b1010101, 8);
    n_cmp++; if (seg_err !== 1'b1) begin n_fail++; $display("FAIL segerr_set: got %b expected 1", seg_err); end
    n_cmp++; if (digit_valid !== 4'b1101) begin n_fail++; $display("FAIL segerr_valid: got %b expected 1101", digit_valid); end
    n_cmp++; if (digits !== 16'h1E3F) begin n_fail++; $display("FAIL segerr_digits: got %h expected 1e3f", digits); end
    n_cmp++; if (upd_cnt - base != 1) begin n_fail++; $display("FAIL segerr_pulses: got %0d expected 1", upd_cnt - base); end
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_cmp++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL segerr_clear: got %b expected 0", seg_err); end
    // New illegal pattern; err_clr arrives in the commit cycle.
    dig_sel = 4'b0010;
    seg_in  = 7'b1010100;
    repeat (SC + 1) @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_cmp++; if (update !== 1'b1) begin n_fail++; $display("FAIL segerr_coincident_update: got %b expected 1", update); end
    n_cmp++; if (seg_err !== 1'b1) begin n_fail++; $display("FAIL segerr_set_wins: got %b expected 1", seg_err); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_sel_err();
    int base;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    n_cmp++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL selerr_preclear: got %b expected 0", seg_err); end
    base = upd_cnt;
    hold(4'b0011, 7'b0000000, 8);
    n_cmp++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL selerr_set: got %b expected 1", sel_err); end
    n_cmp++; if (upd_cnt != base) begin n_fail++; $display("FAIL selerr_pulses: got %0d expected 0", upd_cnt - base); end
    n_cmp++; if (digits !== 16'h1E3F) begin n_fail++; $display("FAIL selerr_digits: got %h expected 1e3f", digits); end
    hold(4'b0100, 7'b1111111, 8);
    n_cmp++; if (digit_valid !== 4'b1001) begin n_fail++; $display("FAIL blank_valid: got %b expected 1001", digit_valid); end
    n_cmp++; if (upd_cnt - base != 1) begin n_fail++; $display("FAIL blank_pulses: got %0d expected 1", upd_cnt - base); end
    n_cmp++; if (upd_idx !== 2'd2) begin n_fail++; $display("FAIL blank_idx: got %0d expected 2", upd_idx); end
    n_cmp++; if (digits !== 16'h1E3F) begin n_fail++; $display("FAIL blank_digits: got %h expected 1e3f", digits); end
    n_cmp++; if (seg_err !== 1'b0) begin n_fail++; $display("FAIL blank_no_err: got %b expected 0", seg_err); end
  endtask

  task automatic test_reset_midrun();
    dig_sel = 4'b1000;
    seg_in  = 7'b0010010;
    repeat (SC + 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({digits, digit_valid, update, upd_idx, seg_err, sel_err} !== 25'b0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", {digits, digit_valid, update, upd_idx, seg_err, sel_err}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (update !== (e == SC + 2)) begin n_fail++; $display("FAIL midrun_edge%0d: update got %b expected %b", e, update, (e == SC + 2)); end
    end
    n_cmp++; if (digits !== 16'h5000) begin n_fail++; $display("FAIL midrun_digits: got %h expected 5000", digits); end
    n_cmp++; if (digit_valid !== 4'b1000) begin n_fail++; $display("FAIL midrun_valid: got %b expected 1000", digit_valid); end
  endtask

  task automatic test_random();
    logic [3:0]  sel, last_sel;
    logic [6:0]  seg, last_seg;
    logic [15:0] e_dig;
    logic [3:0]  e_val;
    logic        e_seg_err, e_sel_err;
    int          e_q[$];
    int          dl[5] = '{3, 4, 5, 6, 9};
    int          d, r, idx, hitk;
    do_reset();
    upd_q.delete();
    e_dig = '0; e_val = '0; e_seg_err = 1'b0; e_sel_err = 1'b0;
    last_sel = 4'b0000; last_seg = 7'h7f;
    for (int n = 0; n < 80; n++) begin
      do begin
        r = $urandom_range(0, 99);
        if (r < 70) sel = 4'b0001 << $urandom_range(0, 3);
        else if (r < 85) sel = 4'b0000;
        else begin
          do sel = 4'($urandom); while ($countones(sel) < 2);
        end
        r = $urandom_range(0, 99);
        if (r < 55) seg = codes[$urandom_range(0, 15)];
        else if (r < 70) seg = 7'h7f;
        else seg = 7'($urandom);
      end while ({sel, seg} == {last_sel, last_seg});
      d = dl[$urandom_range(0, 4)];
      hold(sel, seg, d);
      if (d >= int'(SC)) begin
        if ($countones(sel) > 1) e_sel_err = 1'b1;
        else if (sel != 4'b0000) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (sel[k]) idx = k;
          e_q.push_back(idx);
          hitk = -1;
          for (int k = 0; k < 16; k++) if (codes[k] == seg) hitk = k;
          if (hitk >= 0) begin
            e_dig[4*idx +: 4] = 4'(hitk);
            e_val[idx] = 1'b1;
          end else begin
            e_val[idx] = 1'b0;
            if (seg != 7'h7f) e_seg_err = 1'b1;
          end
        end
      end
      last_sel = sel;
      last_seg = seg;
    end
    hold(4'b0000, 7'h7f, 10);
    n_cmp++; if (digits !== e_dig) begin n_fail++; $display("FAIL rand_digits: got %h expected %h", digits, e_dig); end
    n_cmp++; if (digit_valid !== e_val) begin n_fail++; $display("FAIL rand_valid: got %b expected %b", digit_valid, e_val); end
    n_cmp++; if (seg_err !== e_seg_err) begin n_fail++; $display("FAIL rand_seg_err: got %b expected %b", seg_err, e_seg_err); end
    n_cmp++; if (sel_err !== e_sel_err) begin n_fail++; $display("FAIL rand_sel_err: got %b expected %b", sel_err, e_sel_err); end
    n_cmp++; if (upd_q.size() != e_q.size()) begin n_fail++; $display("FAIL rand_update_count: got %0d expected %0d", upd_q.size(), e_q.size()); end
    for (int k = 0; k < e_q.size() && k < upd_q.size(); k++) begin
      n_cmp++; if (upd_q[k] != e_q[k]) begin n_fail++; $display("FAIL rand_idx%0d: got %0d expected %0d", k, upd_q[k], e_q[k]); end
    end
  endtask

  initial begin
    codes = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    rst_n   = 1'b0;
    seg_in  = 7'h7f;
    dig_sel = 4'b0000;
    err_clr = 1'b0;
    test_reset();
    test_latency();
    test_scan();
    test_toggle();
    test_seg_err();
    test_sel_err();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
